pdp8_xbus_seq: RTL and testbench
================================

PDP8_XBUS_SEQ -- requirements
Module: pdp8_xbus_seq

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, range 0-3: extra bus cycles each data nibble is held before sample/advance.
REQ-002 Parameter ADDR_CACHE, default 1: when 1, the high-address latch cycle is skipped if addr[11:6] matches the last latched value.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  high only in IDLE; transfer accepted when req_valid && req_ready.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_io  input  1  1 = IO device access, 0 = memory access.
REQ-009 req_addr  input  12  memory word address; for IO, [4:0] = device select.
REQ-010 req_wdata  input  12  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  12  read data, valid with rsp_valid, held until next completion.
REQ-013 bus_out  output  8  narrow external bus, registered.
REQ-014 bus_in  input  4  external read nibble.

Function
REQ-015 bus_out encoding: address latch {1,hi,a[5:0]} (hi=1 high six bits, hi=0 low six); data {0,idx[1:0],wr,nib[3:0]} with idx 00/01/10 = bits [11:8]/[7:4]/[3:0]; IO select {0,1,1,dev[4:0]}.
REQ-016 Idle value of bus_out is 8'h00.
REQ-017 States: IDLE, AHI, ALO, IOSEL, DAT0, DAT1, DAT2, IOEND, DONE.
REQ-018 Memory access: IDLE -> AHI -> ALO -> DAT0 -> DAT1 -> DAT2 -> DONE -> IDLE; AHI is omitted when ADDR_CACHE=1, the cache is valid and addr[11:6] matches.
REQ-019 IO access: IDLE -> IOSEL -> DAT0 -> DAT1 -> DAT2 -> IOEND -> DONE -> IDLE; IOEND drives 8'h80 to leave IO mode; the address cache is not modified by IO accesses.
REQ-020 Each address, IOSEL and IOEND state lasts exactly one cycle.
REQ-021 Each DATn state lasts 1+WAIT_CYCLES cycles, controlled by a 2-bit wait counter reloaded on state entry.
REQ-022 Write: DATn drives wr=1 and the nibble of req_wdata for idx n for its full duration.
REQ-023 Read: DATn drives wr=0; bus_in is captured into rdata nibble n on the last cycle of DATn.
REQ-024 rsp_valid is high for exactly the DONE cycle; for writes rsp_rdata is unchanged.
REQ-025 Request fields are registered on acceptance; later input changes do not affect the transfer in flight.
REQ-026 Latency from acceptance to rsp_valid: memory 6+3*WAIT_CYCLES cycles (5+3*WAIT_CYCLES on a cache hit); IO 6+3*WAIT_CYCLES cycles.
REQ-027 req_valid while busy is ignored; no queueing; a new request is accepted no earlier than the cycle after DONE.

Reset
REQ-028 rst asserted at any time, including mid-transfer: state=IDLE, bus_out=8'h00, rsp_valid=0, rsp_rdata=0, address cache invalid, wait counter 0; no rsp_valid is produced for the aborted transfer.
REQ-029 req_ready is 1 in the first cycle after rst deasserts.

Structure
REQ-030 Shared package pdp8_xbus_pkg holds the state enum, the bus_out field-position constants, IDLE_BUS=8'h00 and IOEND_BUS=8'h80.
REQ-031 Single module, no sub-modules; the wait counter is inline.

Verification
REQ-032 Memory write 0x123 <- 0xABC, WAIT_CYCLES=0, cache cold -> bus_out 0xC4, 0xA3, 0x1A, 0x3B, 0x5C, then rsp_valid on the next cycle.
REQ-033 Read 0x124 after REQ-032, bus model returning 0xABC -> bus_out 0xA4, 0x00, 0x20, 0x40 (AHI skipped); rsp_rdata=0xABC; latency 5.
REQ-034 IO read, device 0x05, WAIT_CYCLES=2, bus_in=0x7E1 -> 0x65, three data nibbles each held 3 cycles, 0x80, rsp_rdata=0x7E1; latency 12.
REQ-035 Reset asserted during DAT1 of a write -> bus_out=0x00 immediately; no rsp_valid; next access to the same address issues AHI.
REQ-036 req_valid held high continuously with 4 requests -> each accepted only in IDLE; 4 rsp_valid pulses in request order; bus_out never shows data from two requests interleaved.

Source files
------------

// File: rtl/pdp8_xbus_pkg.sv
// Shared types and bus_out field layout for the PDP-8 narrow external bus sequencer.
// State encoding, field positions, fixed bus codes and small encode helpers.
package pdp8_xbus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        AHI,
        ALO,
        IOSEL,
        DAT0,
        DAT1,
        DAT2,
        IOEND,
        DONE
    } state_t;

    localparam int BUS_MODE_BIT = 7;
    localparam int BUS_HI_BIT   = 6;
    localparam int BUS_IDX_LSB  = 5;
    localparam int BUS_WR_BIT   = 4;
    localparam int BUS_NIB_LSB  = 0;

    localparam logic [1:0] IDX_IOSEL = 2'b11;
    localparam logic [7:0] IDLE_BUS  = 8'h00;
    localparam logic [7:0] IOEND_BUS = 8'h80;

    function automatic logic [7:0] addr_bus(input logic hi, input logic [5:0] a);
        logic [7:0] b;
        b = '0;
        b[BUS_MODE_BIT] = 1'b1;
        b[BUS_HI_BIT]   = hi;
        b[5:0]          = a;
        return b;
    endfunction

    function automatic logic [7:0] data_bus(input logic [1:0] idx, input logic wr,
                                            input logic [3:0] nib);
        logic [7:0] b;
        b = '0;
        b[BUS_IDX_LSB +: 2] = idx;
        b[BUS_WR_BIT]       = wr;
        b[BUS_NIB_LSB +: 4] = nib;
        return b;
    endfunction

    function automatic logic [7:0] iosel_bus(input logic [4:0] dev);
        logic [7:0] b;
        b = '0;
        b[BUS_IDX_LSB +: 2] = IDX_IOSEL;
        b[4:0]              = dev;
        return b;
    endfunction

    function automatic logic is_dat(input state_t s);
        return (s == DAT0) || (s == DAT1) || (s == DAT2);
    endfunction

endpackage

// File: rtl/pdp8_xbus_seq.sv
// Sequences one 12-bit memory or IO transfer over an 8-bit registered bus,
// with nibble-wide data phases, optional wait states and a high-address cache.
module pdp8_xbus_seq
    import pdp8_xbus_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter bit ADDR_CACHE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [11:0] req_addr,
    input  logic [11:0] req_wdata,
    output logic        rsp_valid,
    output logic [11:0] rsp_rdata,
    output logic [7:0]  bus_out,
    input  logic [3:0]  bus_in
);

    localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  wait_cnt;
    logic        wr_q;
    logic        io_q;
    logic [11:0] addr_q;
    logic [11:0] wdata_q;
    logic [11:0] rdata_q;
    logic [11:0] rdata_nxt;
    logic        cache_valid;
    logic [5:0]  cache_hi;
    logic [7:0]  bus_nxt;
    logic [11:0] f_addr;
    logic        accept;
    logic        hit;
    logic        last;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign accept    = req_valid && req_ready;
    assign last      = (wait_cnt == 2'd0);
    assign hit       = ADDR_CACHE && cache_valid && (cache_hi == req_addr[11:6]);
    // Address phases entered straight from IDLE must see the live request.
    assign f_addr    = accept ? req_addr : addr_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid) state_nxt = req_io ? IOSEL : (hit ? ALO : AHI);
            AHI:     state_nxt = ALO;
            ALO:     state_nxt = DAT0;
            IOSEL:   state_nxt = DAT0;
            DAT0:    if (last) state_nxt = DAT1;
            DAT1:    if (last) state_nxt = DAT2;
            DAT2:    if (last) state_nxt = io_q ? IOEND : DONE;
            IOEND:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_nxt = IDLE_BUS;
        case (state_nxt)
            AHI:     bus_nxt = addr_bus(1'b1, f_addr[11:6]);
            ALO:     bus_nxt = addr_bus(1'b0, f_addr[5:0]);
            IOSEL:   bus_nxt = iosel_bus(f_addr[4:0]);
            DAT0:    bus_nxt = data_bus(2'd0, wr_q, wr_q ? wdata_q[11:8] : 4'h0);
            DAT1:    bus_nxt = data_bus(2'd1, wr_q, wr_q ? wdata_q[7:4] : 4'h0);
            DAT2:    bus_nxt = data_bus(2'd2, wr_q, wr_q ? wdata_q[3:0] : 4'h0);
            IOEND:   bus_nxt = IOEND_BUS;
            default: bus_nxt = IDLE_BUS;
        endcase
    end

    always_comb begin
        rdata_nxt = rdata_q;
        case (state)
            DAT0:    rdata_nxt[11:8] = bus_in;
            DAT1:    rdata_nxt[7:4]  = bus_in;
            DAT2:    rdata_nxt[3:0]  = bus_in;
            default: rdata_nxt = rdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus_out     <= IDLE_BUS;
            wait_cnt    <= 2'd0;
            wr_q        <= 1'b0;
            io_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_rdata   <= '0;
            cache_valid <= 1'b0;
            cache_hi    <= '0;
        end else begin
            state   <= state_nxt;
            bus_out <= bus_nxt;
            if (accept) begin
                wr_q    <= req_write;
                io_q    <= req_io;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_nxt != state && is_dat(state_nxt)) begin
                wait_cnt <= WAIT_INIT;
            end else if (!last) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (!wr_q && last && is_dat(state)) begin
                rdata_q <= rdata_nxt;
            end
            // Reads publish once, on DONE entry, so the result is stable between completions.
            if (state_nxt == DONE && state != DONE && !wr_q) begin
                rsp_rdata <= rdata_nxt;
            end
            if (state_nxt == AHI) begin
                cache_hi    <= req_addr[11:6];
                cache_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdp8_xbus_seq.sv
// Scoreboard bench for pdp8_xbus_seq: one instance with no wait states,
// one with two, each fed by a nibble bus model.
module tb_pdp8_xbus_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0;
    logic        v2;
    logic        req_write;
    logic        req_io;
    logic [11:0] req_addr;
    logic [11:0] req_wdata;
    logic        ready0, ready2;
    logic        rsp0, rsp2;
    logic [11:0] rd0, rd2;
    logic [7:0]  bo0, bo2;
    logic [3:0]  bi0, bi2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pdp8_xbus_seq #(.WAIT_CYCLES(0), .ADDR_CACHE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(ready0),
        .req_write(req_write), .req_io(req_io), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp0), .rsp_rdata(rd0),
        .bus_out(bo0), .bus_in(bi0)
    );

    pdp8_xbus_seq #(.WAIT_CYCLES(2), .ADDR_CACHE(1'b1)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(ready2),
        .req_write(req_write), .req_io(req_io), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp2), .rsp_rdata(rd2),
        .bus_out(bo2), .bus_in(bi2)
    );

    typedef struct { int cyc; logic [7:0] v; } bexp_t;
    typedef struct { int cyc; logic [11:0] d; } rexp_t;

    bexp_t bq0[$];
    bexp_t bq1[$];
    rexp_t rq0[$];
    rexp_t rq1[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wcyc[2] = '{0, 2};
    logic        cv[2];
    logic [5:0]  ch[2];
    logic [11:0] last[2];
    logic [11:0] rmod[2] = '{12'h000, 12'h000};

    function automatic logic [3:0] nib_of(input logic [11:0] d, input logic [7:0] b);
        if (b[7] || b[6:5] == 2'b11) return 4'h0;
        case (b[6:5])
            2'b00:   return d[11:8];
            2'b01:   return d[7:4];
            default: return d[3:0];
        endcase
    endfunction

    always_comb bi0 = nib_of(rmod[0], bo0);
    always_comb bi2 = nib_of(rmod[1], bo2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_b(input int s, input int c, input logic [7:0] v);
        bexp_t e;
        e.cyc = c;
        e.v   = v;
        if (s == 0) bq0.push_back(e);
        else        bq1.push_back(e);
    endtask

    task automatic push_r(input int s, input int c, input logic [11:0] d);
        rexp_t e;
        e.cyc = c;
        e.d   = d;
        if (s == 0) rq0.push_back(e);
        else        rq1.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bq0.size() > 0 && bq0[0].cyc == cyc) begin
            chk("bus0", bo0, bq0[0].v);
            void'(bq0.pop_front());
        end
        if (bq1.size() > 0 && bq1[0].cyc == cyc) begin
            chk("bus2", bo2, bq1[0].v);
            void'(bq1.pop_front());
        end
        if (rsp0) begin
            if (rq0.size() == 0) chk("rsp0_spurious", rsp0, 0);
            else begin
                chk("rsp0_cycle", cyc, rq0[0].cyc);
                chk("rsp0_rdata", rd0, rq0[0].d);
                void'(rq0.pop_front());
            end
        end
        if (rsp2) begin
            if (rq1.size() == 0) chk("rsp2_spurious", rsp2, 0);
            else begin
                chk("rsp2_cycle", cyc, rq1[0].cyc);
                chk("rsp2_rdata", rd2, rq1[0].d);
                void'(rq1.pop_front());
            end
        end
    end

    // Waits for acceptance, then queues the cycle-by-cycle bus image and response.
    task automatic issue(input int s, input bit wr, input bit io, input logic [11:0] addr,
                         input logic [11:0] wd, input logic [11:0] rm, input bit hold);
        int n;
        int a;
        int c;
        bit hit;
        logic [3:0] nib;
        n = 0;
        req_write = wr;
        req_io    = io;
        req_addr  = addr;
        req_wdata = wd;
        if (s == 0) v0 = 1'b1;
        else        v2 = 1'b1;
        while (!(s == 0 ? ready0 : ready2)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("accept_timeout", n, 0);
                break;
            end
        end
        rmod[s] = rm;
        a = cyc;
        c = a + 1;
        if (!io) begin
            hit = cv[s] && (ch[s] == addr[11:6]);
            if (!hit) push_b(s, c++, {2'b11, addr[11:6]});
            cv[s] = 1'b1;
            ch[s] = addr[11:6];
            push_b(s, c++, {2'b10, addr[5:0]});
        end else begin
            push_b(s, c++, {3'b011, addr[4:0]});
        end
        for (int i = 0; i < 3; i++) begin
            nib = wr ? wd[11 - 4*i -: 4] : 4'h0;
            for (int k = 0; k <= wcyc[s]; k++) push_b(s, c++, {1'b0, 2'(i), wr, nib});
        end
        if (io) push_b(s, c++, 8'h80);
        push_b(s, c, 8'h00);
        if (!wr) last[s] = rm;
        push_r(s, c, last[s]);
        @(negedge clk);
        if (!hold) begin
            v0 = 1'b0;
            v2 = 1'b0;
        end
        req_addr  = 12'($urandom);
        req_wdata = 12'($urandom);
        req_write = ~wr;
        req_io    = ~io;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0  = 1'b0;
        v2  = 1'b0;
        bq0.delete();
        bq1.delete();
        rq0.delete();
        rq1.delete();
        for (int i = 0; i < 2; i++) begin
            cv[i]   = 1'b0;
            last[i] = 12'h000;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready0", ready0, 1);
        chk("rst_ready2", ready2, 1);
        chk("rst_bus0", bo0, 8'h00);
        chk("rst_bus2", bo2, 8'h00);
        chk("rst_rsp0", rsp0, 0);
        chk("rst_rdata0", rd0, 12'h000);
        chk("rst_rdata2", rd2, 12'h000);
    endtask

    initial begin
        int t;
        rst       = 1'b1;
        v0        = 1'b0;
        v2        = 1'b0;
        req_write = 1'b0;
        req_io    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        do_reset();

        // Cold write, cached read, IO leaves cache intact, boundary miss.
        issue(0, 1'b1, 1'b0, 12'h123, 12'hABC, 12'h000, 1'b0);
        issue(0, 1'b0, 1'b0, 12'h124, 12'h000, 12'hABC, 1'b0);
        issue(0, 1'b1, 1'b1, 12'h00A, 12'h5A3, 12'h000, 1'b0);
        issue(0, 1'b0, 1'b0, 12'h125, 12'h000, 12'h6D9, 1'b0);
        issue(0, 1'b0, 1'b0, 12'hFFF, 12'h000, 12'h0F0, 1'b0);

        // Abort a write in DAT1: AHI, ALO, DAT0, DAT1 follow acceptance.
        issue(0, 1'b1, 1'b0, 12'h3C5, 12'h9B6, 12'h000, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_dat1_bus", bo0, 8'h3B);
        #2 rst = 1'b1;
        #1;
        chk("abort_bus", bo0, 8'h00);
        chk("abort_rsp", rsp0, 0);
        chk("abort_rdata", rd0, 12'h000);
        do_reset();
        issue(0, 1'b0, 1'b0, 12'h3C5, 12'h000, 12'h2E7, 1'b0);

        // Back-to-back with req_valid held high.
        issue(0, 1'b1, 1'b0, 12'h010, 12'h111, 12'h000, 1'b1);
        issue(0, 1'b0, 1'b0, 12'h020, 12'h000, 12'h9C4, 1'b1);
        issue(0, 1'b0, 1'b1, 12'h01F, 12'h000, 12'h3D2, 1'b1);
        issue(0, 1'b1, 1'b0, 12'h7C0, 12'hFED, 12'h000, 1'b0);

        // Two wait states per nibble.
        issue(1, 1'b0, 1'b1, 12'h005, 12'h000, 12'h7E1, 1'b0);
        issue(1, 1'b1, 1'b0, 12'h456, 12'h0C3, 12'h000, 1'b0);
        issue(1, 1'b0, 1'b0, 12'h457, 12'h000, 12'hB5A, 1'b0);

        t = 0;
        while ((bq0.size() + bq1.size() + rq0.size() + rq1.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", bq0.size() + bq1.size() + rq0.size() + rq1.size(), 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
